traffic_timebase: RTL and testbench

//  Timing and input-conditioning front end for the traffic-light controller.

---
 rtl/traffic_timebase.sv | 152 +++++++++++++++
 tb/tb_traffic_timebase.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_timebase.sv
// traffic_timebase: 1 s timebase and pedestrian button conditioning for the
// traffic-light controller. A prescaler divides clk down to a one-cycle tick
// every second. A saturating seconds counter drives the short and long phase
// pulses, and the light FSM restarts the count through reset_counter. The raw
// push-button is synchronised, debounced, and turned into a one-cycle press pulse.
module traffic_timebase #(
    parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
    parameter int unsigned SHORT_SEC       = 1,
    parameter int unsigned LONG_SEC        = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reset_counter,
    input  logic       ped_button_raw,
    output logic       pulse_1s,
    output logic       pulse_10s,
    output logic       pedestrian,
    output logic [7:0] sec_elapsed
);

    localparam int unsigned PRE_W = $clog2(CLK_FREQ_HZ);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_FREQ_HZ - 1);
    localparam logic [7:0]       SEC_SAT   = 8'(LONG_SEC);
    localparam logic [8:0]       SHORT_CMP = 9'(SHORT_SEC);
    localparam logic [8:0]       LONG_CMP  = 9'(LONG_SEC);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] r_presc;
    logic [7:0]       r_sec;
    logic             r_pulse_short;
    logic             r_pulse_long;

    logic             w_tick;
    logic             w_sec_sat;
    logic [8:0]       w_sec_inc;

    // Tick on the last prescaler count; the 9-bit increment keeps the
    // pulse comparisons exact even when the counter sits at 255.
    always_comb begin
        w_tick    = (r_presc == PRE_LAST);
        w_sec_sat = (r_sec == SEC_SAT);
        w_sec_inc = {1'b0, r_sec} + 9'd1;
    end

    // Prescaler: free-running 0..CLK_FREQ_HZ-1, restarted by the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (reset_counter || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Seconds counter: advances on each tick and holds once it reaches LONG_SEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec <= '0;
        end else if (reset_counter) begin
            r_sec <= '0;
        end else if (w_tick && !w_sec_sat) begin
            r_sec <= w_sec_inc[7:0];
        end
    end

    // Phase pulses: registered from the tick that completes the target second.
    // A restart in the same cycle suppresses the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulse_short <= 1'b0;
            r_pulse_long  <= 1'b0;
        end else begin
            r_pulse_short <= w_tick && (w_sec_inc == SHORT_CMP) && !reset_counter;
            r_pulse_long  <= w_tick && (w_sec_inc == LONG_CMP) && !reset_counter;
        end
    end

    // ------------------------------------------------------------------
    // Pedestrian button conditioning
    // ------------------------------------------------------------------
    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_db_level;
    logic            r_db_level_q;
    logic            r_ped;

    logic            w_db_diff;
    logic            w_db_done;

    // The synchronised level differs from the accepted level; accept it
    // once it has stayed different for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        w_db_diff = r_sync2 ^ r_db_level;
        w_db_done = w_db_diff && (r_db_cnt == DB_LAST);
    end

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ped_button_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: runs only while the input disagrees with the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
        end else if (!w_db_diff || w_db_done) begin
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    // Accepted (debounced) button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_level <= 1'b0;
        end else if (w_db_done) begin
            r_db_level <= r_sync2;
        end
    end

    // Rising-edge detect on the accepted level gives one pulse per press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_level_q <= 1'b0;
            r_ped        <= 1'b0;
        end else begin
            r_db_level_q <= r_db_level;
            r_ped        <= r_db_level && !r_db_level_q;
        end
    end

    assign pulse_1s    = r_pulse_short;
    assign pulse_10s   = r_pulse_long;
    assign pedestrian  = r_ped;
    assign sec_elapsed = r_sec;

endmodule

// File: tb/tb_traffic_timebase.sv
// Directed bench for traffic_timebase at a scaled-down clock (10 cycles per
// second, debounce of 4 cycles). Vector table for the timebase, hand-written
// sequences for debounce, asynchronous reset and a closed loop with a
// light-FSM model.
module tb_traffic_timebase;

    logic       clk;
    logic       rst;
    logic       reset_counter;
    logic       ped_button_raw;
    logic       pulse_1s;
    logic       pulse_10s;
    logic       pedestrian;
    logic [7:0] sec_elapsed;

    traffic_timebase #(
        .CLK_FREQ_HZ(10),
        .SHORT_SEC(1),
        .LONG_SEC(10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .reset_counter(reset_counter),
        .ped_button_raw(ped_button_raw),
        .pulse_1s(pulse_1s),
        .pulse_10s(pulse_10s),
        .pedestrian(pedestrian),
        .sec_elapsed(sec_elapsed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Light FSM model used to close the loop
    typedef enum logic [1:0] {L_RED, L_Y1, L_GREEN, L_Y2} lstate_t;
    lstate_t lstate, lnext, lstate_prev;
    logic    loop_en;
    logic    fsm_rc;
    logic    rc_man;

    always_comb begin
        fsm_rc = 1'b0;
        lnext  = lstate;
        case (lstate)
            L_RED:   if (pulse_10s) begin fsm_rc = 1'b1; lnext = L_Y1; end
            L_Y1:    if (pulse_1s) begin fsm_rc = 1'b1; lnext = L_GREEN; end
            L_GREEN: if (pulse_10s || pedestrian) begin fsm_rc = 1'b1; lnext = L_Y2; end
            default: if (pulse_1s) begin fsm_rc = 1'b1; lnext = L_RED; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lstate <= L_RED;
        else if (loop_en && fsm_rc) lstate <= lnext;
    end

    always_comb reset_counter = loop_en ? fsm_rc : rc_man;

    // Bookkeeping
    int unsigned n_checks, n_fail;
    int unsigned ecnt, n1, n10, np, ped_edge;
    int unsigned trans_e[$];
    lstate_t     trans_s[$];

    typedef struct {
        logic        restart;
        int unsigned edge_no;
        logic        rc;
        logic        p1;
        logic        p10;
        logic [7:0]  sec;
        int unsigned n1;
        int unsigned n10;
    } tvec_t;
    tvec_t vecs[$];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Drive inputs for the next edge, advance one edge, sample 1 time unit after it.
    task automatic step(input logic rc, input logic raw);
        rc_man         = rc;
        ped_button_raw = raw;
        @(posedge clk);
        #1;
        rc_man = 1'b0;
        ecnt++;
        if (pulse_1s) n1++;
        if (pulse_10s) n10++;
        if (pedestrian) begin
            np++;
            ped_edge = ecnt;
        end
        if (lstate != lstate_prev) begin
            trans_e.push_back(ecnt);
            trans_s.push_back(lstate);
            lstate_prev = lstate;
        end
    endtask

    task automatic release_rst();
        rst         = 1'b0;
        ecnt        = 0;
        n1          = 0;
        n10         = 0;
        np          = 0;
        ped_edge    = 0;
        lstate_prev = L_RED;
        trans_e.delete();
        trans_s.delete();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        rc_man         = 1'b0;
        ped_button_raw = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_p1", 32'(pulse_1s), 0);
        check("rst_p10", 32'(pulse_10s), 0);
        check("rst_ped", 32'(pedestrian), 0);
        check("rst_sec", 32'(sec_elapsed), 0);
        release_rst();
    endtask

    task automatic add_vec(input logic restart, input int unsigned e, input logic rc,
                           input logic p1, input logic p10, input logic [7:0] sec,
                           input int unsigned c1, input int unsigned c10);
        tvec_t v;
        v.restart = restart; v.edge_no = e; v.rc = rc; v.p1 = p1; v.p10 = p10;
        v.sec = sec; v.n1 = c1; v.n10 = c10;
        vecs.push_back(v);
    endtask

    lstate_t     exp_s[8];
    int unsigned exp_e[8];
    int unsigned p_edge;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        loop_en        = 1'b0;
        rc_man         = 1'b0;
        ped_button_raw = 1'b0;
        rst            = 1'b1;
        ecnt           = 0;
        lstate_prev    = L_RED;

        // restart, edge, rc, pulse_1s, pulse_10s, sec, #pulse_1s, #pulse_10s
        // Free run from reset release, saturation, then restart from saturation
        add_vec(1,   9, 0, 0, 0,  0, 0, 0);
        add_vec(0,  10, 0, 1, 0,  1, 1, 0);
        add_vec(0,  11, 0, 0, 0,  1, 1, 0);
        add_vec(0,  99, 0, 0, 0,  9, 1, 0);
        add_vec(0, 100, 0, 0, 1, 10, 1, 1);
        add_vec(0, 101, 0, 0, 0, 10, 1, 1);
        add_vec(0, 300, 0, 0, 0, 10, 1, 1);
        add_vec(0, 301, 1, 0, 0,  0, 1, 1);
        add_vec(0, 311, 0, 1, 0,  1, 2, 1);
        // Restart mid-count at edge 57
        add_vec(1,  56, 0, 0, 0,  5, 1, 0);
        add_vec(0,  57, 1, 0, 0,  0, 1, 0);
        add_vec(0,  58, 0, 0, 0,  0, 1, 0);
        add_vec(0,  66, 0, 0, 0,  0, 1, 0);
        add_vec(0,  67, 0, 1, 0,  1, 2, 0);
        add_vec(0, 156, 0, 0, 0,  9, 2, 0);
        add_vec(0, 157, 0, 0, 1, 10, 2, 1);
        add_vec(0, 200, 0, 0, 0, 10, 2, 1);
        // Restart in the tick cycle suppresses the pulse
        add_vec(1,   9, 0, 0, 0,  0, 0, 0);
        add_vec(0,  10, 1, 0, 0,  0, 0, 0);
        add_vec(0,  19, 0, 0, 0,  0, 0, 0);
        add_vec(0,  20, 0, 1, 0,  1, 1, 0);
        add_vec(0,  21, 0, 0, 0,  1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].restart) do_reset();
            while (ecnt + 1 < vecs[i].edge_no) step(1'b0, 1'b0);
            step(vecs[i].rc, 1'b0);
            check("vec_p1", 32'(pulse_1s), 32'(vecs[i].p1));
            check("vec_p10", 32'(pulse_10s), 32'(vecs[i].p10));
            check("vec_sec", 32'(sec_elapsed), 32'(vecs[i].sec));
            check("vec_n1", n1, vecs[i].n1);
            check("vec_n10", n10, vecs[i].n10);
        end

        // Debounce: glitches then a held press, release, press with restart active, short glitch
        do_reset();
        repeat (10) step(1'b0, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
        p_edge = ecnt + 1;
        repeat (20) step(1'b0, 1'b1);
        check("ped_first_count", np, 1);
        check("ped_first_edge", ped_edge, p_edge + 6);
        repeat (10) step(1'b0, 1'b0);
        check("ped_release_count", np, 1);
        p_edge = ecnt + 1;
        repeat (12) step(1'b1, 1'b1);
        check("ped_second_count", np, 2);
        check("ped_second_edge", ped_edge, p_edge + 6);
        repeat (10) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0);
        check("ped_glitch3_count", np, 2);

        // Asynchronous reset mid-count with a press being debounced
        do_reset();
        repeat (55) step(1'b0, 1'b0);
        check("t5_pre_sec", 32'(sec_elapsed), 5);
        repeat (3) step(1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_sec", 32'(sec_elapsed), 0);
        check("t5_async_p1", 32'(pulse_1s), 0);
        check("t5_async_p10", 32'(pulse_10s), 0);
        check("t5_async_ped", 32'(pedestrian), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        release_rst();
        repeat (10) step(1'b0, 1'b1);
        check("t5_p1", 32'(pulse_1s), 1);
        check("t5_sec", 32'(sec_elapsed), 1);
        check("t5_ped_edge", ped_edge, 7);
        repeat (90) step(1'b0, 1'b1);
        check("t5_p10", 32'(pulse_10s), 1);
        check("t5_counts", n1 * 100 + n10 * 10 + np, 111);

        // Closed loop with the light FSM; a press in the second GREEN cuts it short
        loop_en = 1'b1;
        do_reset();
        exp_e = '{101, 112, 213, 224, 325, 336, 357, 368};
        exp_s = '{L_Y1, L_GREEN, L_Y2, L_RED, L_Y1, L_GREEN, L_Y2, L_RED};
        repeat (380) step(1'b0, (ecnt + 1 >= 350) && (ecnt + 1 < 370));
        check("loop_trans_count", trans_e.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < trans_e.size()) begin
                check("loop_trans_edge", trans_e[i], exp_e[i]);
                check("loop_trans_state", 32'(trans_s[i]), 32'(exp_s[i]));
            end
        end
        loop_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
